// File: rtl/cache_ctrl_param_if.sv
// Bus bundle for cache_ctrl_param: CPU-side request/response and the
// main-memory request/completion handshake.
//   slave  : the cache controller's view (takes CPU requests, drives memory)
//   master : the environment's view (issues CPU requests, acts as memory)
// Signals:
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU request, held until cpu_ready
//   cpu_ready/cpu_hit/cpu_rdata        one-cycle completion with hit flag/data
//   mem_req/mem_we/mem_addr/mem_wdata  memory request, held until accepted
//   mem_ready                          memory accepts when mem_req & mem_ready
//   mem_done/mem_rdata                 one-cycle completion / read data
interface cache_ctrl_param_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_hit;
    logic [DATA_W-1:0] cpu_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_hit, cpu_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_done, mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_hit, cpu_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_done, mem_rdata
    );
endinterface

// File: rtl/cache_ctrl_param.sv
// Parametrised direct-mapped cache controller with internal tag/valid/dirty/
// data arrays. WRITE_BACK=1 selects write-back + write-allocate with dirty
// victim eviction; WRITE_BACK=0 selects write-through + no-allocate.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        cache_ctrl_param_if.slave (CPU side + memory side)
//   hit_cnt_o  saturating count of completed hits
//   miss_cnt_o saturating count of completed misses
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for cpu_req
// LOOKUP  | tag compare; completes read hits and write-back write hits
// WB_REQ  | requesting write of victim word word_q
// WB_WAIT | waiting mem_done for victim word write
// RF_REQ  | requesting read of refill word word_q
// RF_WAIT | waiting mem_done, stores refill word
// WT_REQ  | requesting write-through of the CPU word
// WT_WAIT | waiting mem_done, then completes the CPU write
module cache_ctrl_param #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int INDEX_W    = 5,
    parameter int OFFSET_W   = 3,
    parameter int WRITE_BACK = 1,
    parameter int STAT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_ctrl_param_if.slave    bus,
    output logic [STAT_W-1:0]    hit_cnt_o,
    output logic [STAT_W-1:0]    miss_cnt_o
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES = 1 << INDEX_W;
    localparam int WPL   = 1 << OFFSET_W;
    localparam bit WB_MODE = (WRITE_BACK != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WB_REQ, S_WB_WAIT,
        S_RF_REQ, S_RF_WAIT, S_WT_REQ, S_WT_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [DATA_W-1:0]   data_q [LINES][WPL];
    logic [LINES-1:0]    valid_q, dirty_q;
    logic [OFFSET_W-1:0] word_q;
    logic                missed_q, wt_hit_q;
    logic [STAT_W-1:0]   hit_cnt_q, miss_cnt_q;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_idx;
    logic [OFFSET_W-1:0] req_off;
    logic                hit, victim_dirty, last_word;

    logic                cpu_ready, cpu_hit, mem_req, mem_we;
    logic [DATA_W-1:0]   cpu_rdata, mem_wdata;
    logic [ADDR_W-1:0]   mem_addr;

    assign {req_tag, req_idx, req_off} = bus.cpu_addr;
    assign hit          = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];
    assign last_word    = &word_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.cpu_req) state_d = S_LOOKUP;
            S_LOOKUP: begin
                if (hit && !bus.cpu_we)          state_d = S_IDLE;
                else if (!WB_MODE && bus.cpu_we) state_d = S_WT_REQ;
                else if (hit)                    state_d = S_IDLE;
                else if (victim_dirty)           state_d = S_WB_REQ;
                else                             state_d = S_RF_REQ;
            end
            S_WB_REQ:  if (bus.mem_ready) state_d = S_WB_WAIT;
            S_WB_WAIT: if (bus.mem_done)  state_d = last_word ? S_RF_REQ : S_WB_REQ;
            S_RF_REQ:  if (bus.mem_ready) state_d = S_RF_WAIT;
            S_RF_WAIT: if (bus.mem_done)  state_d = last_word ? S_LOOKUP : S_RF_REQ;
            S_WT_REQ:  if (bus.mem_ready) state_d = S_WT_WAIT;
            S_WT_WAIT: if (bus.mem_done)  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Memory request fields exist only in *_REQ states, so they drop to zero
    // in the cycle after the accept handshake and everything reads 0 in IDLE.
    always_comb begin
        cpu_ready = 1'b0;
        cpu_hit   = 1'b0;
        cpu_rdata = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_LOOKUP: begin
                if (hit && (!bus.cpu_we || WB_MODE)) begin
                    cpu_ready = 1'b1;
                    cpu_hit   = !missed_q;
                    if (!bus.cpu_we) cpu_rdata = data_q[req_idx][req_off];
                end
            end
            S_WB_REQ: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_q[req_idx], req_idx, word_q};
                mem_wdata = data_q[req_idx][word_q];
            end
            S_RF_REQ: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_idx, word_q};
            end
            S_WT_REQ: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = bus.cpu_addr;
                mem_wdata = bus.cpu_wdata;
            end
            S_WT_WAIT: begin
                if (bus.mem_done) begin
                    cpu_ready = 1'b1;
                    cpu_hit   = wt_hit_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            dirty_q    <= '0;
            word_q     <= '0;
            missed_q   <= 1'b0;
            wt_hit_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.cpu_req) missed_q <= 1'b0;
                S_LOOKUP: begin
                    wt_hit_q <= hit;
                    if (WB_MODE && bus.cpu_we && hit) dirty_q[req_idx] <= 1'b1;
                    if (state_d == S_WB_REQ || state_d == S_RF_REQ) missed_q <= 1'b1;
                end
                S_WB_WAIT: if (bus.mem_done) word_q <= word_q + 1'b1;
                S_RF_WAIT: begin
                    if (bus.mem_done) begin
                        word_q <= word_q + 1'b1;
                        if (last_word) begin
                            valid_q[req_idx] <= 1'b1;
                            dirty_q[req_idx] <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
            if (cpu_ready) begin
                if (cpu_hit) begin
                    if (!(&hit_cnt_q)) hit_cnt_q <= hit_cnt_q + 1'b1;
                end else begin
                    if (!(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + 1'b1;
                end
            end
        end
    end

    // Tag and data storage carry no reset; validity alone qualifies them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_LOOKUP && bus.cpu_we && hit)
                data_q[req_idx][req_off] <= bus.cpu_wdata;
            if (state_q == S_RF_WAIT && bus.mem_done) begin
                data_q[req_idx][word_q] <= bus.mem_rdata;
                if (last_word) tag_q[req_idx] <= req_tag;
            end
        end
    end

    assign bus.cpu_ready = cpu_ready;
    assign bus.cpu_hit   = cpu_hit;
    assign bus.cpu_rdata = cpu_rdata;
    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign hit_cnt_o     = hit_cnt_q;
    assign miss_cnt_o    = miss_cnt_q;
endmodule

// File: tb/tb_cache_ctrl_param.sv
// Directed bench: instance 0 is write-back (16-bit counters), instance 1 is
// write-through (2-bit counters, to reach saturation). A shared memory model
// accepts when ready, completes two cycles later, and holds a[i]^A5A5_0000.
module tb_cache_ctrl_param;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int LIMIT = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [1:0]         req_v   = '0;
    logic [1:0]         we_v    = '0;
    logic [1:0][AW-1:0] addr_v  = '0;
    logic [1:0][DW-1:0] wdata_v = '0;
    logic [1:0]         mrdy_v  = 2'b11;
    logic [1:0]         mdone_v;
    logic [1:0][DW-1:0] mrdata_v;

    logic [1:0]         rdy_v, hit_v, mreq_v, mwe_v;
    logic [1:0][DW-1:0] rdata_v, mwdata_v;
    logic [1:0][AW-1:0] maddr_v;
    logic [1:0][15:0]   hcnt_v, mcnt_v;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int SW = (g == 0) ? 16 : 2;
        logic [SW-1:0] hc, mc;
        cache_ctrl_param_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
        cache_ctrl_param #(
            .ADDR_W(AW), .DATA_W(DW), .INDEX_W(5), .OFFSET_W(3),
            .WRITE_BACK((g == 0) ? 1 : 0), .STAT_W(SW)
        ) u_dut (
            .clk(clk), .rst(rst), .bus(bus),
            .hit_cnt_o(hc), .miss_cnt_o(mc)
        );
        assign bus.cpu_req   = req_v[g];
        assign bus.cpu_we    = we_v[g];
        assign bus.cpu_addr  = addr_v[g];
        assign bus.cpu_wdata = wdata_v[g];
        assign bus.mem_ready = mrdy_v[g];
        assign bus.mem_done  = mdone_v[g];
        assign bus.mem_rdata = mrdata_v[g];
        assign rdy_v[g]    = bus.cpu_ready;
        assign hit_v[g]    = bus.cpu_hit;
        assign rdata_v[g]  = bus.cpu_rdata;
        assign mreq_v[g]   = bus.mem_req;
        assign mwe_v[g]    = bus.mem_we;
        assign maddr_v[g]  = bus.mem_addr;
        assign mwdata_v[g] = bus.mem_wdata;
        assign hcnt_v[g]   = 16'(hc);
        assign mcnt_v[g]   = 16'(mc);
    end

    typedef struct packed {
        logic          g;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;
    ent_t log_q[$];

    logic [DW-1:0] mem_q [2][65536];
    int            cnt_v [2];
    logic [AW-1:0] pa_v  [2];
    logic          pw_v  [2];

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem_q[0][i] = 32'hA5A5_0000 ^ 32'(i);
            mem_q[1][i] = 32'hA5A5_0000 ^ 32'(i);
        end
    end

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            mdone_v[g] <= 1'b0;
            if (rst) begin
                cnt_v[g]    <= 0;
                mrdata_v[g] <= '0;
            end else begin
                if (cnt_v[g] != 0) begin
                    cnt_v[g] <= cnt_v[g] - 1;
                    if (cnt_v[g] == 1) begin
                        mdone_v[g]  <= 1'b1;
                        mrdata_v[g] <= pw_v[g] ? '0 : mem_q[g][pa_v[g]];
                    end
                end
                if (mreq_v[g] && mrdy_v[g]) begin
                    cnt_v[g] <= 2;
                    pa_v[g]  <= maddr_v[g];
                    pw_v[g]  <= mwe_v[g];
                    log_q.push_back('{g: 1'(g), w: mwe_v[g], a: maddr_v[g], d: mwdata_v[g]});
                    if (mwe_v[g]) mem_q[g][maddr_v[g]] <= mwdata_v[g];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks n consecutive log entries from base: instance, direction, address.
    task automatic chk_log(input string tag, input bit s, input int base,
                           input logic [AW-1:0] a0, input logic w, input int n);
        for (int k = 0; k < n; k++) begin
            if (base + k < log_q.size())
                chk($sformatf("%s[%0d]", tag, k),
                    32'({log_q[base+k].g, log_q[base+k].w, log_q[base+k].a}),
                    32'({s, w, a0 + AW'(k)}));
            else
                chk($sformatf("%s[%0d] missing", tag, k), 32'(0), 32'(1));
        end
    endtask

    // Issues one CPU request and waits (bounded) for cpu_ready.
    // cyc = number of clock edges from request until ready is seen.
    task automatic cpu_op(input bit s, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output logic [DW-1:0] rd,
                          output logic h, output int cyc);
        req_v[s] = 1'b1;
        we_v[s] = w;
        addr_v[s] = a;
        wdata_v[s] = d;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!rdy_v[s] && cyc < LIMIT);
        chk("ready_timeout", 32'(rdy_v[s]), 32'(1));
        rd = rdata_v[s];
        h = hit_v[s];
        req_v[s] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] rd;
    logic          h;
    int            cyc;
    int            base;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            chk("rst_ready", 32'(rdy_v[g]), 32'(0));
            chk("rst_memreq", 32'(mreq_v[g]), 32'(0));
            chk("rst_cnts", 32'({hcnt_v[g], mcnt_v[g]}), 32'(0));
        end
        rst = 1'b0;

        // ---------------- write-back instance ----------------
        base = log_q.size();
        cpu_op(0, 1'b0, 16'h0123, '0, rd, h, cyc);
        chk("rd0123_data", rd, 32'hA5A5_0123);
        chk("rd0123_hit", 32'(h), 32'(0));
        chk("rd0123_nmem", 32'(log_q.size() - base), 32'(8));
        chk_log("rd0123_refill", 0, base, 16'h0120, 1'b0, 8);
        chk("rd0123_miss_cnt", 32'(mcnt_v[0]), 32'(1));

        base = log_q.size();
        cpu_op(0, 1'b0, 16'h0125, '0, rd, h, cyc);
        chk("rd0125_lat", 32'(cyc), 32'(1));
        chk("rd0125_hit", 32'(h), 32'(1));
        chk("rd0125_data", rd, 32'hA5A5_0125);
        chk("rd0125_nmem", 32'(log_q.size() - base), 32'(0));
        chk("rd0125_hit_cnt", 32'(hcnt_v[0]), 32'(1));

        base = log_q.size();
        cpu_op(0, 1'b1, 16'h0121, 32'hDEAD_BEEF, rd, h, cyc);
        chk("wr0121_lat", 32'(cyc), 32'(1));
        chk("wr0121_hit", 32'(h), 32'(1));
        chk("wr0121_nmem", 32'(log_q.size() - base), 32'(0));

        base = log_q.size();
        cpu_op(0, 1'b0, 16'h2121, '0, rd, h, cyc);
        chk("rd2121_data", rd, 32'hA5A5_2121);
        chk("rd2121_hit", 32'(h), 32'(0));
        chk("rd2121_nmem", 32'(log_q.size() - base), 32'(16));
        chk_log("rd2121_wb", 0, base, 16'h0120, 1'b1, 8);
        for (int k = 0; k < 8; k++)
            if (base + k < log_q.size())
                chk($sformatf("rd2121_wbdata[%0d]", k), log_q[base+k].d,
                    (k == 1) ? 32'hDEAD_BEEF : (32'hA5A5_0120 + 32'(k)));
        chk_log("rd2121_refill", 0, base + 8, 16'h2120, 1'b0, 8);

        base = log_q.size();
        cpu_op(0, 1'b0, 16'h0121, '0, rd, h, cyc);
        chk("rd0121_data", rd, 32'hDEAD_BEEF);
        chk("rd0121_hit", 32'(h), 32'(0));
        chk("rd0121_nmem", 32'(log_q.size() - base), 32'(8));
        chk_log("rd0121_refill", 0, base, 16'h0120, 1'b0, 8);
        chk("wb_hit_cnt", 32'(hcnt_v[0]), 32'(2));
        chk("wb_miss_cnt", 32'(mcnt_v[0]), 32'(3));

        // refill with memory stalled for 5 cycles on the first word
        mrdy_v[0] = 1'b0;
        base = log_q.size();
        req_v[0] = 1'b1;
        we_v[0] = 1'b0;
        addr_v[0] = 16'h0400;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("stall_req", 32'(mreq_v[0]), 32'(1));
            chk("stall_addr", 32'(maddr_v[0]), 32'h0400);
            chk("stall_noacc", 32'(log_q.size() - base), 32'(0));
            @(posedge clk);
            #1;
        end
        mrdy_v[0] = 1'b1;
        cyc = 0;
        while (!rdy_v[0] && cyc < LIMIT) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("stall_timeout", 32'(rdy_v[0]), 32'(1));
        chk("stall_data", rdata_v[0], 32'hA5A5_0400);
        chk("stall_hit", 32'(hit_v[0]), 32'(0));
        req_v[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("stall_nmem", 32'(log_q.size() - base), 32'(8));
        chk_log("stall_refill", 0, base, 16'h0400, 1'b0, 8);
        chk("stall_miss_cnt", 32'(mcnt_v[0]), 32'(4));

        // reset in the middle of a refill
        base = log_q.size();
        req_v[0] = 1'b1;
        we_v[0] = 1'b0;
        addr_v[0] = 16'h0528;
        cyc = 0;
        while (log_q.size() < base + 3 && cyc < LIMIT) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("midrst_progress", 32'(log_q.size() >= base + 3), 32'(1));
        rst = 1'b1;
        req_v[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_cpu", 32'({rdy_v[0], hit_v[0]}), 32'(0));
        chk("midrst_rdata", rdata_v[0], 32'(0));
        chk("midrst_mem", 32'({mreq_v[0], mwe_v[0], maddr_v[0]}), 32'(0));
        chk("midrst_wdata", mwdata_v[0], 32'(0));
        chk("midrst_cnts", 32'({hcnt_v[0], mcnt_v[0]}), 32'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        base = log_q.size();
        cpu_op(0, 1'b0, 16'h0528, '0, rd, h, cyc);
        chk("rd0528_data", rd, 32'hA5A5_0528);
        chk("rd0528_hit", 32'(h), 32'(0));
        chk("rd0528_nmem", 32'(log_q.size() - base), 32'(8));
        chk_log("rd0528_refill", 0, base, 16'h0528, 1'b0, 8);
        chk("rd0528_cnts", 32'({hcnt_v[0], mcnt_v[0]}), 32'(1));

        // ---------------- write-through instance ----------------
        base = log_q.size();
        cpu_op(1, 1'b1, 16'h0300, 32'h0000_0001, rd, h, cyc);
        chk("wt_wr0300_hit", 32'(h), 32'(0));
        chk("wt_wr0300_nmem", 32'(log_q.size() - base), 32'(1));
        chk_log("wt_wr0300", 1, base, 16'h0300, 1'b1, 1);
        if (base < log_q.size())
            chk("wt_wr0300_wdata", log_q[base].d, 32'h0000_0001);

        base = log_q.size();
        cpu_op(1, 1'b0, 16'h0300, '0, rd, h, cyc);
        chk("wt_rd0300_hit", 32'(h), 32'(0));
        chk("wt_rd0300_data", rd, 32'h0000_0001);
        chk("wt_rd0300_nmem", 32'(log_q.size() - base), 32'(8));
        chk_log("wt_rd0300_refill", 1, base, 16'h0300, 1'b0, 8);

        base = log_q.size();
        cpu_op(1, 1'b1, 16'h0301, 32'h0000_0055, rd, h, cyc);
        chk("wt_wr0301_hit", 32'(h), 32'(1));
        chk("wt_wr0301_nmem", 32'(log_q.size() - base), 32'(1));
        chk_log("wt_wr0301", 1, base, 16'h0301, 1'b1, 1);

        base = log_q.size();
        cpu_op(1, 1'b0, 16'h0301, '0, rd, h, cyc);
        chk("wt_rd0301_lat", 32'(cyc), 32'(1));
        chk("wt_rd0301_hit", 32'(h), 32'(1));
        chk("wt_rd0301_data", rd, 32'h0000_0055);
        chk("wt_rd0301_nmem", 32'(log_q.size() - base), 32'(0));

        cpu_op(1, 1'b0, 16'h0302, '0, rd, h, cyc);
        chk("wt_rd0302_data", rd, 32'hA5A5_0302);
        chk("wt_hit_cnt_3", 32'(hcnt_v[1]), 32'(3));
        cpu_op(1, 1'b0, 16'h0303, '0, rd, h, cyc);
        chk("wt_rd0303_hit", 32'(h), 32'(1));
        chk("wt_hit_cnt_sat", 32'(hcnt_v[1]), 32'(3));
        chk("wt_miss_cnt", 32'(mcnt_v[1]), 32'(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
